// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential 16-bit words from imem and buffers {instr, pc} for decode.
// Optional `IFQ_BYPASS_EN: an acked word reaches decode in the same cycle when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc,
  output logic [15:0] dec_nxt_pc,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        halt_q, err_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [15:0] instr_mem [DEPTH];
  logic [15:0] pc_mem    [DEPTH];
  logic [15:0] last_instr_q, last_pc_q;

  logic halted, ack_ok, push_cand, push, pop, take, bypass, credit, nonempty;

  assign halted    = halt | halt_q;
  assign ack_ok    = imem_ack & req_q;
  assign push_cand = ack_ok & (state_q == WAIT) & ~redirect;
  assign nonempty  = (cnt_q != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = push_cand & ~nonempty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by decode this cycle never occupies a slot.
  assign push = push_cand & ~(bypass & dec_ready);
  assign pop  = nonempty & dec_ready & ~redirect;
  assign take = dec_valid & dec_ready & ~redirect;

  always_comb begin
    cnt_d = cnt_q;
    if (redirect) cnt_d = '0;
    else if (push & ~pop) cnt_d = cnt_q + 1'b1;
    else if (~push & pop) cnt_d = cnt_q - 1'b1;
  end

  // No request is outstanding whenever a new one is considered, so credit is just the next count.
  assign credit = cnt_d < (AW+1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) fetch_pc_d = {redirect_pc[15:1], 1'b0};
    case (state_q)
      IDLE: begin
        if (halted) state_d = HALTED;
        else if (credit) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_d;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_ok) begin
          req_d   = 1'b0;
          state_d = halted ? HALTED : IDLE;
          if (!redirect) begin
            fetch_pc_d = fetch_pc_q + 16'd2;
            if (!halted && credit) begin
              req_d   = 1'b1;
              addr_d  = fetch_pc_d;
              state_d = WAIT;
            end
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (ack_ok) begin
          req_d   = 1'b0;
          state_d = halted ? HALTED : IDLE;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      last_instr_q <= 16'h0800;
      last_pc_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      halt_q     <= halt_q | halt;
      err_q      <= redirect & redirect_pc[0];
      cnt_q      <= cnt_d;
      if (redirect) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
      if (take) begin
        last_instr_q <= dec_instr;
        last_pc_q    <= dec_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= imem_rdata;
      pc_mem[wr_q]    <= fetch_pc_q;
    end
  end

  // Head falls back to the last consumed entry so decode sees stable values while empty.
  always_comb begin
    dec_valid = nonempty;
    dec_instr = nonempty ? instr_mem[rd_q] : last_instr_q;
    dec_pc    = nonempty ? pc_mem[rd_q]    : last_pc_q;
`ifdef IFQ_BYPASS_EN
    if (bypass) begin
      dec_valid = 1'b1;
      dec_instr = imem_rdata;
      dec_pc    = fetch_pc_q;
    end
`endif
  end

  assign dec_nxt_pc = dec_pc + 16'd2;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue (DEPTH=4, default build): memory responder + decode sink.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic [15:0] dec_nxt_pc;
  logic        err;

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_nxt_pc(dec_nxt_pc), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] mpc;
  bit          drop_pend;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: observe/drive at negedge, return 1ns after the following posedge.
  task automatic step(input bit ack, input bit rdy, input bit rd = 1'b0, input logic [15:0] rpc = 16'h0);
    ent_t        e;
    bit          a;
    logic [15:0] nx;
    @(negedge clk);
    a = ack & imem_req;
    if (rdy && dec_valid && !rd) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        nx = e.pc + 16'd2;
        chk("dec_instr", dec_instr, e.instr);
        chk("dec_pc", dec_pc, e.pc);
        chk("dec_nxt_pc", dec_nxt_pc, nx);
      end
    end
    if (a) begin
      if (drop_pend) drop_pend = 1'b0;
      else begin
        chk("imem_addr", imem_addr, mpc);
        if (!rd) begin
          e.instr = mem_f(mpc);
          e.pc    = mpc;
          sb.push_back(e);
          mpc += 16'd2;
        end
      end
    end
    if (rd) begin
      sb.delete();
      if (imem_req && !a) drop_pend = 1'b1;
      mpc = {rpc[15:1], 1'b0};
    end
    imem_ack    = a;
    imem_rdata  = a ? mem_f(imem_addr) : 16'hDEAD;
    dec_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
    imem_ack  = 1'b0;
    redirect  = 1'b0;
    dec_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 1'b1);
    chk("drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    drop_pend = 1'b0;
    mpc = 16'h0000;
    halt = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0; redirect = 1'b0; redirect_pc = 16'h0; dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = 16'h0; redirect = 1'b0; redirect_pc = 16'h0;
    halt = 1'b0; dec_ready = 1'b0; drop_pend = 1'b0; mpc = 16'h0000;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", dec_valid, 0);
    chk("rst_instr", dec_instr, 16'h0800);
    chk("rst_pc", dec_pc, 16'h0000);
    chk("rst_nxt_pc", dec_nxt_pc, 16'h0002);
    chk("rst_err", err, 0);

    // Release: first request on the first edge after rst deasserts.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("req_pre_edge", imem_req, 0);
    @(posedge clk); #1;
    chk("req_first_edge", imem_req, 1);
    chk("addr_first", imem_addr, 16'h0000);

    // Streaming with ack every cycle.
    step(1'b1, 1'b1);
    chk("ack_to_valid", dec_valid, 1);
    repeat (9) step(1'b1, 1'b1);
    drain();

    // Fill to DEPTH with decode stalled.
    repeat (6) step(1'b1, 1'b0);
    chk("full_req", imem_req, 0);
    chk("full_valid", dec_valid, 1);
    step(1'b0, 1'b1);
    chk("refill_req", imem_req, 1);
    chk("refill_addr", imem_addr, mpc);
    step(1'b1, 1'b0);
    chk("refull_req", imem_req, 0);
    drain();

    // Slow memory: request held stable while waiting.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("slow_req", imem_req, 1);
      chk("slow_addr", imem_addr, mpc);
    end
    step(1'b1, 1'b1);
    chk("slow_one_valid", dec_valid, 1);
    step(1'b0, 1'b1);
    chk("slow_one_only", dec_valid, 0);

    // Redirect while waiting: the stale data is dropped.
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("drop_valid", dec_valid, 0);
    chk("drop_req", imem_req, 0);
    repeat (6) step(1'b1, 1'b1);

    // Misaligned redirect: single-cycle err, fetch aligned down.
    step(1'b0, 1'b1, 1'b1, 16'h0031);
    chk("err_pulse", err, 1);
    step(1'b0, 1'b1);
    chk("err_clear", err, 0);
    repeat (6) step(1'b1, 1'b1);

    // Redirect with a same-cycle ack, then address wrap.
    step(1'b1, 1'b1, 1'b1, 16'hFFFC);
    chk("wrap_err", err, 0);
    repeat (8) step(1'b1, 1'b1);
    chk("wrap_err2", err, 0);
    drain();

    // Halt with two queued and one outstanding.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    halt = 1'b1;
    step(1'b0, 1'b0);
    chk("halt_outstanding", imem_req, 1);
    step(1'b1, 1'b0);
    chk("halt_req_drop", imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("halt_no_req", imem_req, 0);
    end
    chk("halt_sb3", sb.size(), 3);
    repeat (3) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("halt_empty_valid", dec_valid, 0);
      chk("halt_empty_req", imem_req, 0);
    end
    chk("halt_sb0", sb.size(), 0);

    // Asynchronous reset mid-operation.
    do_reset();
    repeat (3) step(1'b1, 1'b0);
    chk("pre_rst_valid", dec_valid, 1);
    chk("pre_rst_req", imem_req, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", dec_valid, 0);
    chk("async_rst_req", imem_req, 0);
    sb.delete(); drop_pend = 1'b0; mpc = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step(1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch queue between the instruction-memory port and decode.
- Fetches sequential 16-bit words over a req/ack handshake that tolerates variable memory latency.
- Buffers up to DEPTH {instr, pc} entries and presents them to decode with a valid/ready handshake.
- Handles redirects (branch/jump/JAL from execute) by flushing and refetching, and stops fetching on halt.

Parameters:
- DEPTH, 4, queue entries (power of 2, at least 2).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset; 0 resets the block.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  16  fetch address, registered, held stable while imem_req=1.
- imem_ack  input  1  memory accepted the request; imem_rdata valid this cycle.
- imem_rdata  input  16  fetched instruction.
- redirect  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  16  redirect target.
- halt  input  1  stop issuing fetches; sticky until reset.
- dec_valid  output  1  head entry valid.
- dec_ready  input  1  decode consumes head.
- dec_instr  output  16  head instruction.
- dec_pc  output  16  PC of head instruction.
- dec_nxt_pc  output  16  dec_pc + 2, wraps modulo 2^16.
- err  output  1  one-cycle pulse on misaligned redirect.

Behaviour:
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - dec_valid=0, dec_instr=16'h0800 (NOP), dec_pc=0, dec_nxt_pc=2, err=0.
  - Queue empty, state=IDLE.
- Reset asserted mid-operation discards all entries and any outstanding request immediately.
- At most one request is outstanding. imem_req stays high, with imem_addr unchanged, until the edge on which imem_ack=1.
- Credit: a request issues only if count plus outstanding is less than DEPTH.
- FSM states:
  - IDLE: issue imem_req with imem_addr=fetch_pc when credit is available and not halted, then go to WAIT.
  - WAIT:
    - On ack: push {imem_rdata, fetch_pc}, fetch_pc += 2.
    - If credit remains after the push and not halted, keep imem_req=1 with the new address (back-to-back; stay in WAIT). Otherwise drop req and go to IDLE.
  - DROP: request outstanding but stale. Hold req until ack, discard the data, set req=0, go to IDLE.
  - HALTED: no new requests. Entered from IDLE/WAIT/DROP once halt=1 and no request is outstanding; an outstanding request completes normally first.
- Redirect (highest priority among queue events):
  - Queue flushed (count=0); a same-cycle pop or push is ignored.
  - fetch_pc=redirect_pc with bit0 forced to 0.
  - Redirect in WAIT without a same-cycle ack: go to DROP.
  - Redirect with a same-cycle ack: data discarded, go to IDLE.
  - Redirect in DROP: stay in DROP.
  - Redirect in HALTED: flush and load pc, stay HALTED.
- redirect_pc[0]=1: err=1 for exactly the next cycle.
- Pop occurs when dec_valid and dec_ready. Simultaneous push and pop leaves count unchanged.
- Latency: ack edge to dec_valid=1 is 1 cycle. imem_req first rises on the first clk edge after rst deasserts.
- dec_instr and dec_pc hold their last value when dec_valid=0.
- Address wrap: 16'hFFFE + 2 gives 16'h0000, with no error.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When the queue is empty, no redirect is present, and imem_ack=1, imem_rdata and fetch_pc appear combinationally on dec_instr and dec_pc with dec_valid=1 in the same cycle.
  - If dec_ready=1 the word is consumed and not stored; otherwise it is pushed.
- IFQ_BYPASS_EN undefined: all words pass through the queue, with 1-cycle minimum latency.

Test Plan:
- Reset release, ack every cycle, dec_ready=1: addresses 0, 2, 4, ... issued back-to-back; dec_pc follows 0, 2, 4 one cycle behind ack; dec_nxt_pc = dec_pc + 2.
- dec_ready=0, DEPTH=4: after 4 acks imem_req=0 and count=4. dec_ready=1 for one cycle: one pop, then a single new request at addr 8.
- Ack delayed 3 cycles: imem_req and imem_addr stable for all 4 cycles; exactly one entry pushed.
- Redirect to 16'h0040 while in WAIT, ack 2 cycles later: that data is dropped, dec_valid=0. Next request addr=16'h0040; first dec_pc=16'h0040.
- Redirect to 16'h0031: err pulses exactly 1 cycle; fetch restarts at 16'h0030.
- halt=1 with 2 entries queued and 1 outstanding:
  - The outstanding request completes, then no further requests issue.
  - 3 entries drain, then dec_valid=0 permanently.
  - Asserting rst=0 mid-drain clears dec_valid and imem_req the same instant.
